// File: rtl/lsu_ram_ctl.sv
// lsu_ram_ctl
//   Bridges the load/store stage's single-cycle RAM read/write request onto a
//   valid/ready data-RAM bus. Every access starts with a word read. A store then
//   issues a write with the merged word that the stage builds from the returned
//   read data. The stage is held busy until the access finishes, and a
//   one-cycle done pulse marks completion.
//
// Parameters
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  RAM word width; only 32 is supported (four fixed byte lanes)
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_lsu_valid           stage presents a memory instruction
//   i_lsu_ram_rd_en/addr  read request and byte address
//   i_lsu_ram_wr_en/addr  write request and byte address
//   i_lsu_ram_wr_data     merged full word to write
//   o_ctl_busy            access in flight; stage holds its i_lsu_* inputs
//   o_ctl_done            one-cycle completion pulse
//   o_ctl_rd_data         last read response word (registered)
//   o_ctl_err             sticky flag: response seen outside RD_WAIT
//   o_bus_req_*           request channel (valid/ready, wr, word addr, wdata)
//   i_bus_rsp_*           read response channel
module lsu_ram_ctl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_lsu_valid,
  input  logic                  i_lsu_ram_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_lsu_ram_rd_addr,
  input  logic                  i_lsu_ram_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_lsu_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_lsu_ram_wr_data,
  output logic                  o_ctl_busy,
  output logic                  o_ctl_done,
  output logic [DATA_WIDTH-1:0] o_ctl_rd_data,
  output logic                  o_ctl_err,
  output logic                  o_bus_req_valid,
  input  logic                  i_bus_req_ready,
  output logic                  o_bus_req_wr,
  output logic [ADDR_WIDTH-1:0] o_bus_req_addr,
  output logic [DATA_WIDTH-1:0] o_bus_req_wdata,
  input  logic                  i_bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_bus_rsp_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Clears the byte-lane bits so the bus only ever sees word addresses.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                  state;
  state_t                  state_next;
  logic                    wr_pending;
  logic                    start;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    err;

  assign start = i_lsu_valid && (i_lsu_ram_rd_en || i_lsu_ram_wr_en);

  // State register plus the flag recording whether this access also writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      wr_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        wr_pending <= i_lsu_ram_wr_en;
      end
    end
  end

  // Read word is captured only on a response in RD_WAIT and held otherwise;
  // the stage merges store data from it while the write is outstanding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data <= '0;
    end else if (state == RD_WAIT && i_bus_rsp_valid) begin
      rd_data <= i_bus_rsp_data;
    end
  end

  // Any response outside RD_WAIT is unexpected (writes have no response),
  // so it is dropped and recorded until reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err <= 1'b0;
    end else if (i_bus_rsp_valid && state != RD_WAIT) begin
      err <= 1'b1;
    end
  end

  // Next state and Moore outputs. All outputs derive from the state register,
  // so the asynchronous reset drops the bus request immediately.
  always_comb begin
    state_next      = state;
    o_ctl_busy      = 1'b0;
    o_ctl_done      = 1'b0;
    o_bus_req_valid = 1'b0;
    o_bus_req_wr    = 1'b0;
    o_bus_req_addr  = '0;
    o_bus_req_wdata = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RD_REQ;
        end
      end

      RD_REQ: begin
        o_ctl_busy      = 1'b1;
        o_bus_req_valid = 1'b1;
        o_bus_req_addr  = i_lsu_ram_rd_addr & WORD_MASK;
        if (i_bus_req_ready) begin
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        o_ctl_busy = 1'b1;
        if (i_bus_rsp_valid) begin
          state_next = wr_pending ? WR_REQ : DONE;
        end
      end

      WR_REQ: begin
        o_ctl_busy      = 1'b1;
        o_bus_req_valid = 1'b1;
        o_bus_req_wr    = 1'b1;
        o_bus_req_addr  = i_lsu_ram_wr_addr & WORD_MASK;
        // Passed straight through: the stage keeps it stable while busy.
        o_bus_req_wdata = i_lsu_ram_wr_data;
        if (i_bus_req_ready) begin
          state_next = DONE;
        end
      end

      DONE: begin
        o_ctl_done = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_ctl_rd_data = rd_data;
  assign o_ctl_err     = err;

endmodule

// File: doc/lsu_ram_ctl.md
Name: lsu_ram_ctl

Overview:
- Sits between the load/store stage and the data-RAM bus.
- Turns the stage's single-cycle RAM read/write request into a valid/ready request and response bus transaction.
- Stores always run read-then-write, so the stage can merge sub-word store data into the fetched word.
- Holds the pipeline busy until the access completes, then pulses done.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, RAM word width; must be 32 (byte lanes fixed at 4).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_lsu_valid  in  1  stage has a memory instruction this cycle.
- i_lsu_ram_rd_en  in  1  read requested.
- i_lsu_ram_rd_addr  in  ADDR_WIDTH  read byte address.
- i_lsu_ram_wr_en  in  1  write requested.
- i_lsu_ram_wr_addr  in  ADDR_WIDTH  write byte address.
- i_lsu_ram_wr_data  in  DATA_WIDTH  merged full word to write.
- o_ctl_busy  out  1  access in progress; stage must hold all i_lsu_* stable.
- o_ctl_done  out  1  one-cycle pulse: access complete.
- o_ctl_rd_data  out  DATA_WIDTH  registered read word, fed to the stage's RAM read-data input.
- o_ctl_err  out  1  sticky: spurious bus response seen.
- o_bus_req_valid  out  1  request valid.
- i_bus_req_ready  in  1  request accepted.
- o_bus_req_wr  out  1  1 = write, 0 = read.
- o_bus_req_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- o_bus_req_wdata  out  DATA_WIDTH  write data.
- i_bus_rsp_valid  in  1  read response valid.
- i_bus_rsp_data  in  DATA_WIDTH  read response word.

Behaviour:
- Reset: state IDLE; all outputs 0, including o_ctl_rd_data and o_ctl_err. Reset asserted mid-operation drops o_bus_req_valid immediately (asynchronously) and abandons the access; no done pulse is produced.
- State machine states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE. Transitions are evaluated on the rising edge.
- IDLE:
  - o_ctl_busy = 0.
  - If i_lsu_valid && (rd_en || wr_en): latch wr_en into a local flag and move to RD_REQ.
  - Otherwise stay in IDLE.
  - A write always goes through RD_REQ first (read-modify-write).
- RD_REQ:
  - valid = 1, wr = 0, addr = {rd_addr[ADDR_WIDTH-1:2], 2'b00}.
  - On i_bus_req_ready, move to RD_WAIT.
  - valid and addr stay stable until accepted.
- RD_WAIT:
  - On i_bus_rsp_valid, register i_bus_rsp_data into o_ctl_rd_data.
  - Next state is WR_REQ if the write flag is set, else DONE.
  - No timeout.
- WR_REQ:
  - valid = 1, wr = 1, addr = {wr_addr[ADDR_WIDTH-1:2], 2'b00}, wdata = i_lsu_ram_wr_data.
  - wdata is passed through combinationally; it is stable because o_ctl_rd_data and the stage inputs are held.
  - On ready, move to DONE.
  - Write responses are not expected.
- DONE:
  - o_ctl_done = 1 for exactly one cycle, then IDLE.
  - o_ctl_busy = 0 in DONE.
- o_ctl_busy = 1 in RD_REQ, RD_WAIT and WR_REQ.
- o_ctl_rd_data holds its value until the next read response; it is never cleared except by reset.
- i_bus_rsp_valid in any state other than RD_WAIT: data ignored, o_ctl_err set; it stays set until reset.
- Request in the DONE cycle: not accepted; it is taken in the following IDLE cycle. Back-to-back accesses therefore have a minimum spacing of one IDLE cycle.
- i_lsu_valid with both enables at 0: no action.
- Latency, with ready and response returned at the earliest opportunity:
  - Load: accept at T, RD_REQ at T+1, RD_WAIT at T+2, done at T+3.
  - Store: done at T+4.
  - Each stall cycle on ready or response adds one cycle.

Test Plan:
- Load, zero-wait bus: rd_addr = 0x8000_0006, rsp = 0xDEAD_BEEF → bus addr 0x8000_0004, wr = 0; o_ctl_rd_data = 0xDEAD_BEEF; done at T+3; busy high for exactly T+1..T+2.
- Store: wr_addr = 0x8000_0001, stage supplies wdata 0x1122_AA44 after read of 0x1122_3344 → read then write to 0x8000_0000 with wdata 0x1122_AA44; done at T+4.
- Ready held low 3 cycles in RD_REQ and 2 cycles in WR_REQ → valid, addr and wdata stable throughout; done at T+9.
- Response delayed 5 cycles → busy stays high; o_ctl_rd_data updates only on the response edge.
- Spurious i_bus_rsp_valid while IDLE → o_ctl_err = 1 and stays set; o_ctl_rd_data unchanged.
- i_rst pulsed while in RD_WAIT → valid, busy and done go to 0 at once; a later response is flagged in o_ctl_err; the next load completes normally.
